// File: rtl/can_req_sched_if.sv
// can_req_sched_if: bundle between the round-robin CAN request scheduler and
// its environment (per-channel requesters plus the CAN TX/RX datapath).
//   master : scheduler side; drives tx_start/tx_ch/done/fail/busy.
//   slave  : environment side; drives time_limit/max_retry/req/tx_done/rx_*.
interface can_req_sched_if #(
   parameter int unsigned NCH = 4,
   parameter int unsigned RW  = 2
);
   localparam int unsigned CW = $clog2(NCH);
   localparam int unsigned TW = 32;

   logic [TW-1:0]  time_limit;
   logic [RW-1:0]  max_retry;
   logic [NCH-1:0] req;
   logic           tx_start;
   logic [CW-1:0]  tx_ch;
   logic           tx_done;
   logic           rx_valid;
   logic [CW-1:0]  rx_ch;
   logic [NCH-1:0] done;
   logic [NCH-1:0] fail;
   logic           busy;

   modport master (
      input  time_limit, max_retry, req, tx_done, rx_valid, rx_ch,
      output tx_start, tx_ch, done, fail, busy
   );

   modport slave (
      output time_limit, max_retry, req, tx_done, rx_valid, rx_ch,
      input  tx_start, tx_ch, done, fail, busy
   );
endinterface

// File: rtl/can_req_sched.sv
// can_req_sched: shares one CAN TX path and one response timer among NCH
// requesters. Grants round-robin, launches TX, waits for the matching
// response, retries on timeout up to max_retry, then reports done/fail.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-low reset
//   bus  - can_req_sched_if.master (requests, TX launch, RX response,
//          programmable timeout/retry, done/fail pulses, busy)
module can_req_sched #(
   parameter int unsigned NCH = 4,
   parameter int unsigned RW  = 2
) (
   input  logic            clk,
   input  logic            rst,
   can_req_sched_if.master bus
);
   localparam int unsigned CW = $clog2(NCH);
   localparam int unsigned TW = 32;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEND    = 3'd1;
   localparam logic [2:0] S_WAIT_TX = 3'd2;
   localparam logic [2:0] S_WAIT_RX = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [2:0] S_FAIL    = 3'd5;

   logic [2:0]     state, state_d;
   logic [CW-1:0]  tx_ch_q, tx_ch_d;
   logic [CW-1:0]  last_q, last_d;
   logic [RW-1:0]  retry_q, retry_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           tx_start_q, tx_start_d;
   logic           busy_q, busy_d;
   logic [NCH-1:0] done_q, done_d;
   logic [NCH-1:0] fail_q, fail_d;

   logic           grant_vld_c;
   logic [CW-1:0]  grant_ch_c;
   logic [CW-1:0]  scan_c;
   logic           rx_match_c;
   logic           timeout_c;

   // Round-robin pick: first set req bit searching upward from last+1.
   always_comb begin
      grant_vld_c = 1'b0;
      grant_ch_c  = '0;
      scan_c      = '0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         scan_c = CW'((32'(last_q) + i) % NCH);
         if (!grant_vld_c && bus.req[scan_c]) begin
            grant_vld_c = 1'b1;
            grant_ch_c  = scan_c;
         end
      end
   end

   // A matching response wins over a timeout in the same cycle.
   assign rx_match_c = bus.rx_valid && (bus.rx_ch == tx_ch_q);
   assign timeout_c  = (timer_q >= bus.time_limit);

   // Next-state and next-output logic; outputs are registered from *_d.
   always_comb begin
      state_d = state;
      tx_ch_d = tx_ch_q;
      last_d  = last_q;
      retry_d = retry_q;
      timer_d = timer_q;

      case (state)
         S_IDLE: begin
            if (grant_vld_c) begin
               tx_ch_d = grant_ch_c;
               retry_d = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            state_d = S_WAIT_TX;
         end
         S_WAIT_TX: begin
            if (bus.tx_done) begin
               timer_d = '0;
               state_d = S_WAIT_RX;
            end
         end
         S_WAIT_RX: begin
            // Saturating timer: never wraps back below time_limit.
            if (timer_q != '1) begin
               timer_d = timer_q + TW'(1);
            end
            if (rx_match_c) begin
               state_d = S_DONE;
            end else if (timeout_c) begin
               if (retry_q < bus.max_retry) begin
                  retry_d = retry_q + RW'(1);
                  state_d = S_SEND;
               end else begin
                  state_d = S_FAIL;
               end
            end
         end
         S_DONE, S_FAIL: begin
            last_d  = tx_ch_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      tx_start_d = (state_d == S_SEND);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE) ? (NCH'(1) << tx_ch_d) : '0;
      fail_d     = (state_d == S_FAIL) ? (NCH'(1) << tx_ch_d) : '0;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         tx_ch_q    <= '0;
         last_q     <= CW'(NCH - 1);
         retry_q    <= '0;
         timer_q    <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= '0;
         fail_q     <= '0;
      end else begin
         state      <= state_d;
         tx_ch_q    <= tx_ch_d;
         last_q     <= last_d;
         retry_q    <= retry_d;
         timer_q    <= timer_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         fail_q     <= fail_d;
      end
   end

   assign bus.tx_start = tx_start_q;
   assign bus.tx_ch    = tx_ch_q;
   assign bus.done     = done_q;
   assign bus.fail     = fail_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_can_req_sched.sv
// tb_can_req_sched: directed bench for can_req_sched. Inputs change 1 time
// unit after a rising edge and outputs are sampled there as well.
module tb_can_req_sched;
   localparam int unsigned NCH = 4;
   localparam int unsigned RW  = 2;

   logic clk = 1'b0;
   logic rst;
   int   nvec = 0;
   int   nerr = 0;
   logic [1:0] exp_ch;

   can_req_sched_if #(.NCH(NCH), .RW(RW)) bif ();

   can_req_sched #(.NCH(NCH), .RW(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] onehot(input logic [1:0] ch);
      logic [31:0] v;
      v = 32'd1 << ch;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      nvec++;
      assert (obs === exp_v)
      else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic outs(input string tag, input logic ts, input logic [1:0] ch,
                       input logic [3:0] dn, input logic [3:0] fl, input logic bz);
      chk({tag, ".tx_start"}, 32'(bif.tx_start), 32'(ts));
      chk({tag, ".tx_ch"},    32'(bif.tx_ch),    32'(ch));
      chk({tag, ".done"},     32'(bif.done),     32'(dn));
      chk({tag, ".fail"},     32'(bif.fail),     32'(fl));
      chk({tag, ".busy"},     32'(bif.busy),     32'(bz));
   endtask

   initial begin
      // Reset
      rst = 1'b0;
      bif.req = 4'b0000;
      bif.time_limit = 32'd10;
      bif.max_retry = 2'd0;
      bif.tx_done = 1'b0;
      bif.rx_valid = 1'b0;
      bif.rx_ch = 2'd0;
      tick();
      tick();
      outs("reset", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
      rst = 1'b1;

      // Round robin: all requesting, each served with minimum latency
      bif.req = 4'b1111;
      bif.tx_done = 1'b1;
      bif.rx_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_ch = 2'(k % 4);
         bif.rx_ch = exp_ch;
         tick(); outs("rr_send", 1'b1, exp_ch, 4'h0, 4'h0, 1'b1);
         tick(); outs("rr_wtx", 1'b0, exp_ch, 4'h0, 4'h0, 1'b1);
         tick(); outs("rr_wrx", 1'b0, exp_ch, 4'h0, 4'h0, 1'b1);
         tick(); outs("rr_done", 1'b0, exp_ch, 4'(onehot(exp_ch)), 4'h0, 1'b1);
         tick(); outs("rr_idle", 1'b0, exp_ch, 4'h0, 4'h0, 1'b0);
      end
      bif.req = 4'b0000;
      bif.tx_done = 1'b0;
      bif.rx_valid = 1'b0;
      tick(); outs("idle_quiet", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);

      // Single success: tx_done 3 cycles after tx_start, response in 4th WAIT_RX cycle
      bif.time_limit = 32'd10;
      bif.max_retry = 2'd0;
      bif.req = 4'b0001;
      tick(); outs("s1_send", 1'b1, 2'd0, 4'h0, 4'h0, 1'b1);
      tick(); outs("s1_wtx", 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
      tick();
      tick();
      bif.tx_done = 1'b1;
      tick(); outs("s1_wrx0", 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
      bif.tx_done = 1'b0;
      tick();
      tick();
      tick(); outs("s1_wrx3", 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
      bif.rx_valid = 1'b1;
      bif.rx_ch = 2'd0;
      tick(); outs("s1_done", 1'b0, 2'd0, 4'h1, 4'h0, 1'b1);
      bif.rx_valid = 1'b0;
      bif.req = 4'b0000;
      tick(); outs("s1_idle", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);

      // Timeout with two retries, then fail
      bif.time_limit = 32'd5;
      bif.max_retry = 2'd2;
      bif.req = 4'b0001;
      bif.tx_done = 1'b1;
      tick();
      for (int a = 0; a < 3; a++) begin
         outs("to_send", 1'b1, 2'd0, 4'h0, 4'h0, 1'b1);
         tick(); chk("to_wtx.tx_start", 32'(bif.tx_start), 32'd0);
         repeat (6) tick();
         outs("to_t5", 1'b0, 2'd0, 4'h0, 4'h0, 1'b1);
         tick();
      end
      outs("to_fail", 1'b0, 2'd0, 4'h0, 4'h1, 1'b1);
      bif.req = 4'b0000;
      bif.tx_done = 1'b0;
      tick(); outs("to_idle", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);

      // Wrong-channel response is ignored; channel 1 times out
      bif.time_limit = 32'd3;
      bif.max_retry = 2'd0;
      bif.req = 4'b0010;
      bif.tx_done = 1'b1;
      bif.rx_valid = 1'b1;
      bif.rx_ch = 2'd2;
      tick(); outs("wc_send", 1'b1, 2'd1, 4'h0, 4'h0, 1'b1);
      tick();
      repeat (4) tick();
      outs("wc_t3", 1'b0, 2'd1, 4'h0, 4'h0, 1'b1);
      tick(); outs("wc_fail", 1'b0, 2'd1, 4'h0, 4'h2, 1'b1);
      bif.req = 4'b0000;
      bif.rx_valid = 1'b0;
      tick(); outs("wc_idle", 1'b0, 2'd1, 4'h0, 4'h0, 1'b0);

      // Matching response on the exact timeout cycle wins, no retry
      bif.max_retry = 2'd1;
      bif.req = 4'b0010;
      tick(); outs("sc_send", 1'b1, 2'd1, 4'h0, 4'h0, 1'b1);
      tick();
      repeat (4) tick();
      bif.rx_valid = 1'b1;
      bif.rx_ch = 2'd1;
      tick(); outs("sc_done", 1'b0, 2'd1, 4'h2, 4'h0, 1'b1);
      bif.req = 4'b0000;
      bif.rx_valid = 1'b0;
      bif.tx_done = 1'b0;
      tick(); outs("sc_idle", 1'b0, 2'd1, 4'h0, 4'h0, 1'b0);

      // time_limit = 0 and max_retry = 0: fail after first WAIT_RX cycle
      bif.time_limit = 32'd0;
      bif.max_retry = 2'd0;
      bif.req = 4'b0100;
      bif.tx_done = 1'b1;
      tick(); outs("z_send", 1'b1, 2'd2, 4'h0, 4'h0, 1'b1);
      tick();
      tick(); outs("z_wrx0", 1'b0, 2'd2, 4'h0, 4'h0, 1'b1);
      tick(); outs("z_fail", 1'b0, 2'd2, 4'h0, 4'h4, 1'b1);
      bif.req = 4'b0000;
      tick(); outs("z_idle", 1'b0, 2'd2, 4'h0, 4'h0, 1'b0);

      // Reset in WAIT_RX, then arbitration restarts from channel 0
      bif.time_limit = 32'd10;
      bif.req = 4'b0010;
      tick(); outs("r_send", 1'b1, 2'd1, 4'h0, 4'h0, 1'b1);
      tick();
      tick();
      tick();
      tick(); outs("r_wrx2", 1'b0, 2'd1, 4'h0, 4'h0, 1'b1);
      rst = 1'b0;
      bif.req = 4'b1001;
      tick(); outs("r_rst1", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
      tick(); outs("r_rst2", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
      rst = 1'b1;
      bif.rx_valid = 1'b1;
      bif.rx_ch = 2'd0;
      tick(); outs("r0_send", 1'b1, 2'd0, 4'h0, 4'h0, 1'b1);
      tick();
      tick();
      tick(); outs("r0_done", 1'b0, 2'd0, 4'h1, 4'h0, 1'b1);
      bif.req = 4'b1000;
      bif.rx_ch = 2'd3;
      tick(); outs("r0_idle", 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
      tick(); outs("r3_send", 1'b1, 2'd3, 4'h0, 4'h0, 1'b1);
      tick();
      tick();
      tick(); outs("r3_done", 1'b0, 2'd3, 4'h8, 4'h0, 1'b1);
      bif.req = 4'b0000;
      bif.rx_valid = 1'b0;
      bif.tx_done = 1'b0;
      tick(); outs("r3_idle", 1'b0, 2'd3, 4'h0, 4'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/can_req_sched.md
# can_req_sched

Round-robin request/response scheduler that shares one CAN transmit path and one response-timeout timer among `NCH` requesters (bus channels). It grants one channel at a time, launches its transmit, and arms the timeout. It then waits for the matching response and retries on timeout up to a programmable count. It sits between the per-channel request logic and the CAN TX/RX datapath in the hub.

## Interface
- `NCH`, 4: number of requesting channels (2..16).
- `CW`, `$clog2(NCH)`: channel index width.
- `RW`, 2: retry counter width.
- `clk` in 1: system clock, 40 MHz, 25 ns period.
- `rst` in 1: reset, synchronous, active-low.
- `time_limit` in 32: response timeout in clk cycles; sampled every cycle.
- `max_retry` in RW: retransmissions allowed after the first attempt.
- `req` in NCH: level request per channel; held until that channel's `done` or `fail` pulse.
- `tx_start` out 1: one-cycle pulse that launches transmission for `tx_ch`.
- `tx_ch` out CW: granted channel; stable from SEND through DONE/FAIL.
- `tx_done` in 1: TX path finished the frame (pulse).
- `rx_valid` in 1: response received (pulse).
- `rx_ch` in CW: channel the response belongs to.
- `done` out NCH: one-hot one-cycle pulse; response received.
- `fail` out NCH: one-hot one-cycle pulse; retries exhausted.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, SEND, WAIT_TX, WAIT_RX, DONE, FAIL.
- IDLE: if any `req` is set, select the first set bit searching upward from `last+1` (mod NCH), latch it into `tx_ch`, clear `retry_cnt`, and go to SEND. `last` resets to NCH-1, so channel 0 has first priority.
- SEND: assert `tx_start` for exactly one cycle, then go to WAIT_TX.
- WAIT_TX: stay until `tx_done` = 1. Then clear `timer` to 0 and go to WAIT_RX.
- WAIT_RX: `timer` increments by 1 each cycle and saturates at 2^32-1, never wrapping.
  - A matching response is `rx_valid` with `rx_ch == tx_ch`. It goes to DONE.
  - A timeout is `timer >= time_limit` with no matching response that cycle.
  - A matching response takes priority over a timeout in the same cycle.
  - On timeout with `retry_cnt < max_retry`: increment `retry_cnt` and go to SEND.
  - On timeout with `retry_cnt == max_retry`: go to FAIL.
- `rx_valid` with a non-matching `rx_ch`, or arriving in any state other than WAIT_RX, is ignored.
- DONE and FAIL: pulse the `done` or `fail` bit for `tx_ch` for one cycle, set `last = tx_ch`, and go to IDLE.
- If a requester drops `req` mid-transaction, the transaction still completes. `req` is only sampled in IDLE.
- Arithmetic is unsigned throughout. `retry_cnt` is RW bits wide and never exceeds `max_retry`.

## Timing
- Reset values: `tx_start`=0, `tx_ch`=0, `done`=0, `fail`=0, `busy`=0, state IDLE, `timer`=0, `retry_cnt`=0, `last`=NCH-1.
- Reset asserted in any state returns the block to IDLE on the next edge with no `done`/`fail` pulse.
- All outputs are registered.
- Transaction timeline, with `req` high at edge t:
  - SEND is entered at t+1, so `tx_start` is high in cycle t+1.
  - WAIT_TX is entered at t+2.
  - `tx_done` sampled at edge u: WAIT_RX is entered at u+1 with `timer`=0.
  - Matching response sampled at edge v: `done` is high in cycle v+1 and IDLE is entered at v+2.
- Timeout latency: with `time_limit`=L ≥ 1, the L+1 consecutive WAIT_RX cycles hold `timer` = 0..L, and the timeout fires on the edge where `timer` = L. With L=0 it fires on the first WAIT_RX cycle.
- Retry turnaround: timeout edge → SEND → `tx_start` in the next cycle.
- Minimum transaction length (IDLE → IDLE): 5 cycles.
- Back-to-back requests get no extra arbitration cycle; the next grant is taken in the IDLE cycle.

## Test plan
- Single success: `req`=0001, `time_limit`=10, `tx_done` 3 cycles after `tx_start`, response with `rx_ch`=0 after 4 WAIT_RX cycles → one `tx_start`, `done`=0001 pulse, `busy` low 2 cycles after the response.
- Timeout with retries: `time_limit`=5, `max_retry`=2, `tx_done` immediate, no response → 3 `tx_start` pulses, each retry 6 WAIT_RX cycles after WAIT_RX entry, then `fail`=0001.
- Round-robin: `req`=1111 held, each served immediately → grant order 0,1,2,3,0, each with its own `done` bit.
- Wrong-channel and same-cycle: `rx_ch`=2 while serving channel 1 → ignored, times out. Matching `rx_valid` on the exact timeout cycle → `done`, no retry.
- Edge limits: `time_limit`=0 → timeout on first WAIT_RX cycle. `max_retry`=0 → single attempt, then `fail`.
- Reset mid-WAIT_RX → outputs at reset values next cycle, no `done`/`fail`. Afterwards `req`=1000 is served normally.
